// File: rtl/mips_cpu_alu_regfile_if.sv
// Datapath bundle between the multicycle CPU control FSM and
// the register file / ALU core.
interface mips_cpu_alu_regfile_if;
   logic [4:0]  rs_index;
   logic [4:0]  rt_index;
   logic [4:0]  write_index;
   logic        write_enable;
   logic [31:0] write_data;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [15:0] immediate;
   logic        carry_in;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] alu_result;
   logic        carry_out;
   logic        zero;
   logic        branch;
   logic [31:0] register_v0;

   modport master (
      output rs_index, rt_index, write_index,
      output write_enable, write_data,
      output opcode, funct, shamt, immediate,
      output carry_in,
      input  rs_data, rt_data, alu_result,
      input  carry_out, zero, branch, register_v0
   );

   modport slave (
      input  rs_index, rt_index, write_index,
      input  write_enable, write_data,
      input  opcode, funct, shamt, immediate,
      input  carry_in,
      output rs_data, rt_data, alu_result,
      output carry_out, zero, branch, register_v0
   );
endinterface

// File: rtl/mips_cpu_alu_regfile.sv
// Multicycle MIPS datapath core: 32x32 register file with two
// combinational read ports plus a combinational ALU/branch unit.
module mips_cpu_alu_regfile (
   input logic                   clk,
   input logic                   reset,
   mips_cpu_alu_regfile_if.slave bus
);
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   logic [31:0] regs [0:31];

   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] se;
   logic [31:0] ze;
   logic [32:0] add_ab;
   logic [32:0] sub_ab;
   logic [32:0] add_ai;
   logic [4:0]  sh_var;
   logic        lt_s;
   logic        lt_u;
   logic        lt_si;
   logic        lt_ui;
   logic        a_zero;
   logic        is_rtype;
   logic        is_mem;
   logic        is_bcmp;
   logic        is_regimm;
   logic [31:0] result;
   logic        cout;
   logic        br;

   // Register 0 is never written, so reset leaves it at zero for good.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.write_enable && (bus.write_index != 5'd0)) begin
         regs[bus.write_index] <= bus.write_data;
      end
   end

   assign bus.rs_data     = (bus.rs_index == 5'd0) ? '0 : regs[bus.rs_index];
   assign bus.rt_data     = (bus.rt_index == 5'd0) ? '0 : regs[bus.rt_index];
   assign bus.register_v0 = regs[2];

   assign a  = bus.rs_data;
   assign b  = bus.rt_data;
   assign se = {{16{bus.immediate[15]}}, bus.immediate};
   assign ze = {16'h0000, bus.immediate};

   assign add_ab = {1'b0, a} + {1'b0, b};
   assign sub_ab = {1'b0, a} + {1'b0, ~b} + 33'd1;
   assign add_ai = {1'b0, a} + {1'b0, se};
   assign sh_var = a[4:0];

   assign lt_s   = $signed(a) < $signed(b);
   assign lt_u   = a < b;
   assign lt_si  = $signed(a) < $signed(se);
   assign lt_ui  = a < se;
   assign a_zero = (a == 32'd0);

   assign is_rtype  = (bus.opcode == OP_RTYPE);
   assign is_regimm = (bus.opcode == OP_REGIMM);
   assign is_mem    = (bus.opcode >= 6'h20) && (bus.opcode <= 6'h2B);
   assign is_bcmp   = (bus.opcode >= OP_BEQ) && (bus.opcode <= OP_BGTZ);

   always_comb begin
      result = '0;
      cout   = bus.carry_in;
      br     = 1'b0;
      unique case (1'b1)
         is_rtype: begin
            case (bus.funct)
               FN_SLL:  result = b << bus.shamt;
               FN_SRL:  result = b >> bus.shamt;
               FN_SRA:  result = $signed(b) >>> bus.shamt;
               FN_SLLV: result = b << sh_var;
               FN_SRLV: result = b >> sh_var;
               FN_SRAV: result = $signed(b) >>> sh_var;
               FN_JR,
               FN_JALR: result = a;
               FN_ADD,
               FN_ADDU: begin
                  result = add_ab[31:0];
                  cout   = add_ab[32];
               end
               FN_SUB,
               FN_SUBU: begin
                  result = sub_ab[31:0];
                  cout   = sub_ab[32];
               end
               FN_AND:  result = a & b;
               FN_OR:   result = a | b;
               FN_XOR:  result = a ^ b;
               FN_NOR:  result = ~(a | b);
               FN_SLT:  result = {31'd0, lt_s};
               FN_SLTU: result = {31'd0, lt_u};
               default: result = '0;
            endcase
         end
         is_regimm: begin
            result = sub_ab[31:0];
            case (bus.rt_index)
               5'd0,
               5'd16:   br = a[31];
               5'd1,
               5'd17:   br = ~a[31];
               default: br = 1'b0;
            endcase
         end
         is_bcmp: begin
            result = sub_ab[31:0];
            case (bus.opcode)
               OP_BEQ:  br = (a == b);
               OP_BNE:  br = (a != b);
               OP_BLEZ: br = a[31] | a_zero;
               OP_BGTZ: br = ~a[31] & ~a_zero;
               default: br = 1'b0;
            endcase
         end
         is_mem: begin
            result = add_ai[31:0];
         end
         default: begin
            case (bus.opcode)
               OP_ADDIU: begin
                  result = add_ai[31:0];
                  cout   = add_ai[32];
               end
               OP_SLTI:  result = {31'd0, lt_si};
               OP_SLTIU: result = {31'd0, lt_ui};
               OP_ANDI:  result = a & ze;
               OP_ORI:   result = a | ze;
               OP_XORI:  result = a ^ ze;
               OP_LUI:   result = {bus.immediate, 16'h0000};
               default:  result = '0;
            endcase
         end
      endcase
   end

   assign bus.alu_result = result;
   assign bus.carry_out  = cout;
   assign bus.zero       = (result == 32'd0);
   assign bus.branch     = br;
endmodule

// File: tb/tb_mips_cpu_alu_regfile.sv
// Directed self-checking bench for the MIPS register file / ALU core.
module tb_mips_cpu_alu_regfile;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   mips_cpu_alu_regfile_if bus ();

   mips_cpu_alu_regfile dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] idx, input logic [31:0] data);
      @(negedge clk);
      bus.write_index  = idx;
      bus.write_data   = data;
      bus.write_enable = 1'b1;
      @(posedge clk);
      #1;
      bus.write_enable = 1'b0;
   endtask

   task automatic alu(input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] sh, input logic [15:0] imm);
      bus.opcode    = op;
      bus.funct     = fn;
      bus.rs_index  = rs;
      bus.rt_index  = rt;
      bus.shamt     = sh;
      bus.immediate = imm;
      #1;
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      reset            = 1'b0;
      bus.rs_index     = '0;
      bus.rt_index     = '0;
      bus.write_index  = '0;
      bus.write_enable = 1'b0;
      bus.write_data   = '0;
      bus.opcode       = '0;
      bus.funct        = '0;
      bus.shamt        = '0;
      bus.immediate    = '0;
      bus.carry_in     = 1'b0;
      #2;
      check("reset_v0", bus.register_v0, 32'h0);
      bus.rs_index = 5'd5;
      #1;
      check("reset_r5", bus.rs_data, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // register file basics
      wr(5'd2, 32'hDEADBEEF);
      bus.rs_index = 5'd2;
      #1;
      check("rd_r2", bus.rs_data, 32'hDEADBEEF);
      check("v0", bus.register_v0, 32'hDEADBEEF);
      wr(5'd0, 32'd5);
      bus.rs_index = 5'd0;
      bus.rt_index = 5'd0;
      #1;
      check("r0_rs", bus.rs_data, 32'h0);
      check("r0_rt", bus.rt_data, 32'h0);

      // same-cycle read returns the old value
      @(negedge clk);
      bus.rs_index     = 5'd4;
      bus.write_index  = 5'd4;
      bus.write_data   = 32'h00001234;
      bus.write_enable = 1'b1;
      #1;
      check("no_bypass", bus.rs_data, 32'h0);
      @(posedge clk);
      #1;
      bus.write_enable = 1'b0;
      check("after_wr", bus.rs_data, 32'h00001234);

      // add / sub with carry
      wr(5'd1, 32'hFFFFFFFF);
      wr(5'd3, 32'd1);
      alu(6'h00, 6'h21, 5'd1, 5'd3, 5'd0, 16'h0);
      check("addu_res", bus.alu_result, 32'h0);
      check("addu_zero", {31'd0, bus.zero}, 32'd1);
      check("addu_cout", {31'd0, bus.carry_out}, 32'd1);
      alu(6'h00, 6'h23, 5'd3, 5'd1, 5'd0, 16'h0);
      check("subu_res", bus.alu_result, 32'd2);
      check("subu_cout", {31'd0, bus.carry_out}, 32'd0);
      check("subu_zero", {31'd0, bus.zero}, 32'd0);
      bus.carry_in = 1'b1;
      alu(6'h00, 6'h24, 5'd1, 5'd3, 5'd0, 16'h0);
      check("and_res", bus.alu_result, 32'd1);
      check("and_cin", {31'd0, bus.carry_out}, 32'd1);
      bus.carry_in = 1'b0;
      alu(6'h00, 6'h27, 5'd0, 5'd3, 5'd0, 16'h0);
      check("nor", bus.alu_result, 32'hFFFFFFFE);
      alu(6'h00, 6'h10, 5'd1, 5'd3, 5'd0, 16'h0);
      check("mfhi_0", bus.alu_result, 32'h0);

      // shifts and compares
      wr(5'd1, 32'h80000000);
      alu(6'h00, 6'h03, 5'd0, 5'd1, 5'd4, 16'h0);
      check("sra", bus.alu_result, 32'hF8000000);
      alu(6'h00, 6'h02, 5'd0, 5'd1, 5'd4, 16'h0);
      check("srl", bus.alu_result, 32'h08000000);
      alu(6'h00, 6'h00, 5'd0, 5'd3, 5'd31, 16'h0);
      check("sll", bus.alu_result, 32'h80000000);
      alu(6'h00, 6'h07, 5'd3, 5'd1, 5'd0, 16'h0);
      check("srav", bus.alu_result, 32'hC0000000);
      alu(6'h00, 6'h2A, 5'd1, 5'd3, 5'd0, 16'h0);
      check("slt", bus.alu_result, 32'd1);
      alu(6'h00, 6'h2B, 5'd1, 5'd3, 5'd0, 16'h0);
      check("sltu", bus.alu_result, 32'd0);
      alu(6'h00, 6'h08, 5'd1, 5'd0, 5'd0, 16'h0);
      check("jr", bus.alu_result, 32'h80000000);

      // immediates
      alu(6'h09, 6'h00, 5'd0, 5'd0, 5'd0, 16'hFFFF);
      check("addiu", bus.alu_result, 32'hFFFFFFFF);
      alu(6'h0D, 6'h00, 5'd0, 5'd0, 5'd0, 16'hFFFF);
      check("ori", bus.alu_result, 32'h0000FFFF);
      alu(6'h0F, 6'h00, 5'd0, 5'd0, 5'd0, 16'hFFFF);
      check("lui", bus.alu_result, 32'hFFFF0000);
      alu(6'h23, 6'h00, 5'd3, 5'd0, 5'd0, 16'hFFFF);
      check("lw_addr", bus.alu_result, 32'h0);
      check("lw_nobr", {31'd0, bus.branch}, 32'd0);
      alu(6'h0A, 6'h00, 5'd3, 5'd0, 5'd0, 16'hFFFF);
      check("slti", bus.alu_result, 32'd0);
      alu(6'h0B, 6'h00, 5'd3, 5'd0, 5'd0, 16'hFFFF);
      check("sltiu", bus.alu_result, 32'd1);

      // branches
      wr(5'd1, 32'hFFFFFFFF);
      alu(6'h04, 6'h00, 5'd1, 5'd1, 5'd0, 16'h0);
      check("beq", {31'd0, bus.branch}, 32'd1);
      check("beq_res", bus.alu_result, 32'h0);
      alu(6'h05, 6'h00, 5'd1, 5'd1, 5'd0, 16'h0);
      check("bne", {31'd0, bus.branch}, 32'd0);
      alu(6'h06, 6'h00, 5'd1, 5'd0, 5'd0, 16'h0);
      check("blez", {31'd0, bus.branch}, 32'd1);
      alu(6'h07, 6'h00, 5'd1, 5'd0, 5'd0, 16'h0);
      check("bgtz", {31'd0, bus.branch}, 32'd0);
      alu(6'h07, 6'h00, 5'd3, 5'd0, 5'd0, 16'h0);
      check("bgtz_pos", {31'd0, bus.branch}, 32'd1);
      alu(6'h01, 6'h00, 5'd1, 5'd0, 5'd0, 16'h0);
      check("bltz", {31'd0, bus.branch}, 32'd1);
      alu(6'h01, 6'h00, 5'd1, 5'd1, 5'd0, 16'h0);
      check("bgez", {31'd0, bus.branch}, 32'd0);
      alu(6'h01, 6'h00, 5'd1, 5'd17, 5'd0, 16'h0);
      check("bgezal", {31'd0, bus.branch}, 32'd0);
      alu(6'h01, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0);
      check("regimm_bad", {31'd0, bus.branch}, 32'd0);
      alu(6'h03, 6'h00, 5'd1, 5'd3, 5'd0, 16'h1234);
      check("jal_res", bus.alu_result, 32'h0);
      check("jal_nobr", {31'd0, bus.branch}, 32'd0);

      // async reset clears everything and blocks writes
      for (int i = 1; i < 32; i++) begin
         wr(i[4:0], 32'h00000100 + i);
      end
      bus.rs_index = 5'd31;
      #1;
      check("fill_r31", bus.rs_data, 32'h0000011F);
      @(negedge clk);
      #2;
      bus.write_index  = 5'd5;
      bus.write_data   = 32'h77;
      bus.write_enable = 1'b1;
      reset            = 1'b0;
      #1;
      check("rst_v0", bus.register_v0, 32'h0);
      for (int i = 1; i < 32; i++) begin
         bus.rs_index = i[4:0];
         #0.1;
         check($sformatf("rst_r%0d", i), bus.rs_data, 32'h0);
      end
      @(posedge clk);
      #1;
      bus.rs_index = 5'd5;
      #1;
      check("rst_blocks_wr", bus.rs_data, 32'h0);
      @(negedge clk);
      bus.write_enable = 1'b0;
      reset            = 1'b1;
      wr(5'd7, 32'hCAFEF00D);
      bus.rt_index = 5'd7;
      #1;
      check("post_rst_wr", bus.rt_data, 32'hCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
